// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg
// Shared constants for the pipelined ripple-carry adder: default operand
// width, default slice width, and the stage-count helper used by the top.
package pipe_rca_pkg;

  localparam int PIPE_RCA_WIDTH = 16;
  localparam int PIPE_RCA_SLICE = 4;

  // Number of pipeline stages for a given operand and slice width.
  function automatic int stage_count(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// Single-bit full-adder cell.
// Ports:
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o, cout_o   : sum bit and carry-out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_slice.sv
// rca_slice
// Combinational W-bit ripple-carry adder built from full_adder cells.
// Ports:
//   a_i, b_i : W-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : W-bit sum
//   cout_o   : carry out of bit W-1
//   cmsb_o   : carry into bit W-1 (used for signed overflow at the top slice)
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o = carry[W];
  assign cmsb_o = carry[W-1];

endmodule

// File: rtl/pipe_rca.sv
// pipe_rca
// Pipelined ripple-carry adder/subtractor. Each stage adds one SLICE-bit
// slice and registers its partial result, so no combinational path spans
// more than one slice. Valid/ready handshake on both sides; the whole pipe
// advances together whenever in_ready is high.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : input handshake
//   a, b, cin, sub      : operands, carry-in (add only), 1 = subtract
//   out_valid, out_ready: output handshake
//   sum, cout, ovf      : result, carry out (no-borrow when subtracting),
//                         signed overflow
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = PIPE_RCA_WIDTH,
  parameter int SLICE = PIPE_RCA_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, SLICE);

  // Per-stage registers. Operands are stored pre-shifted so that each stage
  // always consumes the low SLICE bits; the sum is shifted in from the top
  // so it lands in place after the last stage.
  logic             v_q    [STAGES];
  logic             c_q    [STAGES];
  logic             cmsb_q [STAGES];
  logic             sub_q  [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];

  logic             v_d    [STAGES];
  logic             c_d    [STAGES];
  logic             cmsb_d [STAGES];
  logic             sub_d  [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [WIDTH-1:0] s_d    [STAGES];

  assign in_ready = !v_q[STAGES-1] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             v_in;
    logic             sub_in;
    logic             c_in;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] s_slice;
    logic             c_out;
    logic             c_msb;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b;
      assign s_in   = '0;
      assign v_in   = in_valid;
      assign sub_in = sub;
      // Subtract is a + ~b + 1, so cin is replaced by a forced 1.
      assign c_in   = sub ? 1'b1 : cin;
    end else begin : g_next
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign s_in   = s_q[k-1];
      assign v_in   = v_q[k-1];
      assign sub_in = sub_q[k-1];
      assign c_in   = c_q[k-1];
    end

    assign b_slice = sub_in ? ~b_in[SLICE-1:0] : b_in[SLICE-1:0];

    rca_slice #(.W(SLICE)) u_slice (
      .a_i    (a_in[SLICE-1:0]),
      .b_i    (b_slice),
      .cin_i  (c_in),
      .sum_o  (s_slice),
      .cout_o (c_out),
      .cmsb_o (c_msb)
    );

    assign v_d[k]    = v_in;
    assign c_d[k]    = c_out;
    assign cmsb_d[k] = c_msb;
    assign sub_d[k]  = sub_in;
    assign a_d[k]    = a_in >> SLICE;
    assign b_d[k]    = b_in >> SLICE;
    assign s_d[k]    = (s_in >> SLICE) | (WIDTH'(s_slice) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= 1'b0;
        c_q[k]    <= 1'b0;
        cmsb_q[k] <= 1'b0;
        sub_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= v_d[k];
        c_q[k]    <= c_d[k];
        cmsb_q[k] <= cmsb_d[k];
        sub_q[k]  <= sub_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        s_q[k]    <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ cmsb_q[STAGES-1];

endmodule

// File: tb/tb_pipe_rca.sv
module tb_pipe_rca;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_rca #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_rca #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic and sign rules.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] r;
    logic        v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    v  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {v, r[16], r[15:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                     input logic c, input logic s);
    logic [7:0] yy;
    logic [8:0] r;
    logic       v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : c)};
    v  = (x[7] == yy[7]) && (r[7] != x[7]);
    return {v, r[8], r[7:0]};
  endfunction

  // Single operation through the 16-bit pipe; checks latency and result.
  task automatic run_one16(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                           input logic xc, input logic xs, input logic [15:0] es,
                           input logic ec, input logic eo);
    int lat;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    step();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sc [8];
    logic        ss [8];
    logic [17:0] held;
    logic [9:0]  q8 [$];
    int sent, rcv, stall, stale, lat;

    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;

    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid8", out_valid8, 0);
    rst = 1'b0;

    // First operation accepted on the first edge after release.
    run_one16("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one16("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one16("5_minus_7",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one16("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_one16("8000_minus_1",16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one16("mixed_sign",  16'h7FFF, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-to-back stream with a 3-cycle stall after the 2nd result.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 1'($urandom);
      ss[i] = 1'($urandom);
    end
    sent = 0; rcv = 0; stall = 0; held = '0;
    for (int it = 0; it < 80 && rcv < 8; it++) begin
      out_ready = (stall == 0);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = sa[sent]; b = sb[sent]; cin = sc[sent]; sub = ss[sent];
      end
      #1;
      if (stall > 0) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        if (stall == 3) held = {ovf, cout, sum};
        else check("stall_hold", {ovf, cout, sum}, held);
      end
      if (stall > 0) stall--;
      if (out_valid && out_ready) begin
        check("stream_result", {ovf, cout, sum}, ref16(sa[rcv], sb[rcv], sc[rcv], ss[rcv]));
        rcv++;
        if (rcv == 2) stall = 3;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", rcv, 8);
    step();

    // Reset with operations in flight.
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 * 16'(i + 1); b = 16'h0200; cin = 0; sub = 0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sum", sum, 16'h0300);
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_sum", sum, 0);
    step();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("no_stale_after_rst", stale, 0);
    run_one16("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Single-stage configuration.
    a8 = 8'h80; b8 = 8'h80; cin8 = 0; sub8 = 0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      step();
      lat++;
    end
    check("w8_latency", lat, 1);
    check("w8_sum", sum8, 8'h00);
    check("w8_cout", cout8, 1);
    check("w8_ovf", ovf8, 1);
    step();

    sent = 0; rcv = 0;
    for (int it = 0; it < 40000 && rcv < 10000; it++) begin
      out_ready8 = ($urandom_range(0, 3) != 0);
      in_valid8  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      #1;
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) check("w8_unexpected_output", 1, 0);
        else check("w8_random", {ovf8, cout8, sum8}, q8.pop_front());
        rcv++;
      end
      if (in_valid8 && in_ready8) begin
        q8.push_back(ref8(a8, b8, cin8, sub8));
        sent++;
      end
      step();
    end
    in_valid8 = 1'b0;
    check("w8_random_count", rcv, 10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_rca.md
PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, the bits added per pipeline stage; WIDTH SHALL be an integer multiple of SLICE, with STAGES = WIDTH/SLICE.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  operand set accepted when in_valid && in_ready.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used only in add mode.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add mode SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-017 Subtract mode SHALL compute a + ~b + 1, ignoring cin.
REQ-018 ovf SHALL equal the carry into bit WIDTH-1 XOR cout.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add slice bits [k*SLICE +: SLICE]. Stage k SHALL take its carry from stage k-1's register; stage 0 SHALL take it from cin, or from 1 in subtract mode.
REQ-020 Each stage SHALL register its slice sum, its carry, a valid bit and all still-unprocessed upper operand bits. Mode SHALL be captured with the operands, so no combinational path crosses more than one slice.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be one operation per cycle.
REQ-022 in_ready SHALL equal !out_valid || out_ready; every pipeline register SHALL advance only when in_ready is 1.
REQ-023 While stalled (out_valid=1, out_ready=0), sum, cout and ovf SHALL remain stable, and no operation SHALL be lost or duplicated.
REQ-024 An empty stage (valid=0) SHALL advance as a bubble. out_valid SHALL be 0 whenever the final stage holds a bubble.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 When in_valid=0 while in_ready=1, a bubble SHALL enter stage 0; operand values are don't-care.
REQ-027 When STAGES = 1 the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-028 Asserting rst SHALL immediately clear all stage valid bits, so out_valid=0 and in_ready=1; sum, cout, ovf and all data registers SHALL become 0.
REQ-029 Operations in flight when rst asserts SHALL be discarded, with no output after reset release.
REQ-030 The first operation SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-031 Package pipe_rca_pkg SHALL hold the default WIDTH and SLICE constants and a stage-count function WIDTH/SLICE.
REQ-032 Sub-module rca_slice SHALL be a combinational SLICE-bit ripple adder (a, b, cin -> sum, cout, and carry into its MSB), built from the existing full-adder cell. It SHALL be instantiated once per stage.

Verification (WIDTH=16, SLICE=4 unless stated)
REQ-033 a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
REQ-034 a=0x7FFF, b=0x0001, cin=0, add -> sum=0x8000, cout=0, ovf=1; then a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-035 8 back-to-back random operations, with out_ready=0 for 3 cycles after the 2nd result -> outputs held stable while stalled, in_ready=0 during the stall, all 8 results correct and in order.
REQ-036 rst pulsed with 3 operations in flight -> out_valid=0 immediately, no stale result after release, a fresh operation completes in 4 cycles.
REQ-037 WIDTH=8, SLICE=8: a=0x80, b=0x80, add -> sum=0x00, cout=1, ovf=1 with latency 1. Plus 10^4 random operations checked against a reference model.
